// File: rtl/sdram_sched.sv
// SDRAM command scheduler: power-up init sequencing, then arbitration of the shared
// SDRAM bus between the write, refresh and read engines, with a refresh timer and a watchdog.
module sdram_sched #(
  parameter int INIT_DELAY = 10000,
  parameter int REF_PERIOD = 390,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       init_done,
  input  logic       wr_done,
  input  logic       rd_done,
  input  logic       ref_done,
  output logic [3:0] sel,
  output logic       init_start,
  output logic       wr_start,
  output logic       rd_start,
  output logic       ref_start,
  output logic       wr_ack,
  output logic       rd_ack,
  output logic       ready,
  output logic       busy,
  output logic       ref_overrun,
  output logic       timeout_err
);

  // state    | meaning
  // PWR_WAIT | power-up wait, counting INIT_DELAY
  // INIT     | init engine running, waiting for init_done
  // IDLE     | bus parked on the read engine (NOP), arbitration
  // REF      | refresh engine owns the bus
  // WR       | write engine owns the bus
  // RD       | read engine owns the bus
  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_IDLE, S_REF, S_WR, S_RD
  } state_t;

  localparam int PW = $clog2(INIT_DELAY + 1);
  localparam int RW = $clog2(REF_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [PW-1:0] pwr_cnt;
  logic [RW-1:0] ref_cnt;
  logic [TW-1:0] wd_cnt;
  logic          ref_pending, last_wr;
  logic          grant_ref, grant_wr, grant_rd;
  logic          init_ok, abort, wd_expired, ref_wrap;

  function automatic logic [3:0] sel_of(state_t s);
    case (s)
      S_PWR_WAIT, S_INIT: sel_of = 4'b0001;
      S_WR:               sel_of = 4'b0010;
      S_REF:              sel_of = 4'b0100;
      default:            sel_of = 4'b1000;
    endcase
  endfunction

  assign wd_expired = (wd_cnt == '0);
  assign ref_wrap   = ready && (ref_cnt == '0);

  always_comb begin
    state_nx  = state;
    grant_ref = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    init_ok   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_PWR_WAIT: if (pwr_cnt == '0) state_nx = S_INIT;
      S_INIT: begin
        if (init_done) begin
          state_nx = S_IDLE;
          init_ok  = 1'b1;
        end else if (wd_expired) begin
          state_nx = S_PWR_WAIT;
          abort    = 1'b1;
        end
      end
      S_IDLE: begin
        // On a write/read tie, the side not granted last wins.
        if (ref_pending) begin
          state_nx  = S_REF;
          grant_ref = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr)) begin
          state_nx = S_WR;
          grant_wr = 1'b1;
        end else if (rd_req) begin
          state_nx = S_RD;
          grant_rd = 1'b1;
        end
      end
      S_REF, S_WR, S_RD: begin
        if ((state == S_REF && ref_done) || (state == S_WR && wr_done) ||
            (state == S_RD && rd_done)) begin
          state_nx = S_IDLE;
        end else if (wd_expired) begin
          state_nx = S_IDLE;
          abort    = 1'b1;
        end
      end
      default: state_nx = S_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_PWR_WAIT;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_cnt     <= PW'(INIT_DELAY - 1);
      ref_cnt     <= RW'(REF_PERIOD - 1);
      wd_cnt      <= TW'(TIMEOUT - 1);
      ref_pending <= 1'b0;
      last_wr     <= 1'b0;
      sel         <= 4'b0001;
      init_start  <= 1'b0;
      wr_start    <= 1'b0;
      rd_start    <= 1'b0;
      ref_start   <= 1'b0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      ready       <= 1'b0;
      busy        <= 1'b1;
      ref_overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Counters reload while outside their active states, so entry always starts fresh.
      pwr_cnt <= (state == S_PWR_WAIT) ? pwr_cnt - 1'b1 : PW'(INIT_DELAY - 1);
      wd_cnt  <= (state inside {S_PWR_WAIT, S_IDLE}) ? TW'(TIMEOUT - 1) : wd_cnt - 1'b1;
      if (ready) ref_cnt <= ref_wrap ? RW'(REF_PERIOD - 1) : ref_cnt - 1'b1;

      if (ref_wrap)       ref_pending <= 1'b1;
      else if (grant_ref) ref_pending <= 1'b0;
      if (ref_wrap && ref_pending && !grant_ref) ref_overrun <= 1'b1;
      if (abort)   timeout_err <= 1'b1;
      if (init_ok) ready       <= 1'b1;
      if (grant_wr)      last_wr <= 1'b1;
      else if (grant_rd) last_wr <= 1'b0;

      sel        <= sel_of(state_nx);
      busy       <= (state_nx != S_IDLE);
      init_start <= (state == S_PWR_WAIT) && (state_nx == S_INIT);
      wr_start   <= grant_wr;
      wr_ack     <= grant_wr;
      rd_start   <= grant_rd;
      rd_ack     <= grant_rd;
      ref_start  <= grant_ref;
    end
  end

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched: two instances share all inputs, one with a long
// refresh period and one with short refresh/watchdog settings for timeout scenarios.
module tb_sdram_sched;
  logic clk = 1'b0;
  logic rst, wr_req, rd_req, init_done, wr_done, rd_done, ref_done;
  logic [3:0] sel_a, sel_b;
  logic init_start_a, wr_start_a, rd_start_a, ref_start_a, wr_ack_a, rd_ack_a;
  logic ready_a, busy_a, ref_overrun_a, timeout_err_a;
  logic init_start_b, wr_start_b, rd_start_b, ref_start_b, wr_ack_b, rd_ack_b;
  logic ready_b, busy_b, ref_overrun_b, timeout_err_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sdram_sched #(.INIT_DELAY(20), .REF_PERIOD(50), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .init_done(init_done),
    .wr_done(wr_done), .rd_done(rd_done), .ref_done(ref_done), .sel(sel_a),
    .init_start(init_start_a), .wr_start(wr_start_a), .rd_start(rd_start_a),
    .ref_start(ref_start_a), .wr_ack(wr_ack_a), .rd_ack(rd_ack_a), .ready(ready_a),
    .busy(busy_a), .ref_overrun(ref_overrun_a), .timeout_err(timeout_err_a));

  sdram_sched #(.INIT_DELAY(20), .REF_PERIOD(5), .TIMEOUT(10)) dut_b (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .init_done(init_done),
    .wr_done(wr_done), .rd_done(rd_done), .ref_done(ref_done), .sel(sel_b),
    .init_start(init_start_b), .wr_start(wr_start_b), .rd_start(rd_start_b),
    .ref_start(ref_start_b), .wr_ack(wr_ack_b), .rd_ack(rd_ack_b), .ready(ready_b),
    .busy(busy_b), .ref_overrun(ref_overrun_b), .timeout_err(timeout_err_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_up();
    int n = 0;
    bit seen = 0;
    bit sel_ok = 1;
    rst = 1; wr_req = 0; rd_req = 0; init_done = 0; wr_done = 0; rd_done = 0; ref_done = 0;
    tick(); tick();
    rst = 0;
    total++; if (sel_a !== 4'b0001) begin bad++; $display("FAIL rst_sel got=%b exp=0001", sel_a); end
    total++; if (busy_a !== 1'b1 || ready_a !== 1'b0) begin bad++; $display("FAIL rst_busy_ready got=%b%b exp=10", busy_a, ready_a); end
    total++; if (timeout_err_a !== 1'b0 || ref_overrun_a !== 1'b0 || init_start_a !== 1'b0 || wr_ack_a !== 1'b0)
      begin bad++; $display("FAIL rst_flags got=%b%b%b%b exp=0000", timeout_err_a, ref_overrun_a, init_start_a, wr_ack_a); end
    while (!seen && n < 40) begin
      tick(); n++;
      if (sel_a !== 4'b0001) sel_ok = 0;
      if (init_start_a === 1'b1) seen = 1;
    end
    total++; if (!seen || n != 20) begin bad++; $display("FAIL init_start_cycle got=%0d seen=%0d exp=20", n, seen); end
    total++; if (!sel_ok) begin bad++; $display("FAIL pwr_wait_sel got=not_0001 exp=0001"); end
    tick();
    total++; if (init_start_a !== 1'b0) begin bad++; $display("FAIL init_start_width got=%b exp=0", init_start_a); end
    repeat (4) tick();
    total++; if (ready_a !== 1'b0 || sel_a !== 4'b0001) begin bad++; $display("FAIL init_wait got=%b/%b exp=0/0001", ready_a, sel_a); end
    init_done = 1; tick(); init_done = 0;
    total++; if (ready_a !== 1'b1 || sel_a !== 4'b1000 || busy_a !== 1'b0)
      begin bad++; $display("FAIL init_done got=%b/%b/%b exp=1/1000/0", ready_a, sel_a, busy_a); end
    total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL init_done_b got=%b exp=1", ready_b); end
  endtask

  task automatic test_init_timeout();
    int n = 0;
    bit seen = 0;
    rst = 1; tick(); tick(); rst = 0;
    while (!seen && n < 40) begin tick(); n++; if (init_start_b === 1'b1) seen = 1; end
    repeat (9) tick();
    total++; if (timeout_err_b !== 1'b0 || sel_b !== 4'b0001) begin bad++; $display("FAIL init_wd_early got=%b/%b exp=0/0001", timeout_err_b, sel_b); end
    tick();
    total++; if (timeout_err_b !== 1'b1 || ready_b !== 1'b0 || busy_b !== 1'b1 || sel_b !== 4'b0001)
      begin bad++; $display("FAIL init_wd got=%b/%b/%b/%b exp=1/0/1/0001", timeout_err_b, ready_b, busy_b, sel_b); end
    total++; if (timeout_err_a !== 1'b0) begin bad++; $display("FAIL init_wd_a got=%b exp=0", timeout_err_a); end
    n = 0; seen = 0;
    while (!seen && n < 40) begin tick(); n++; if (init_start_b === 1'b1) seen = 1; end
    total++; if (!seen || n != 20) begin bad++; $display("FAIL init_retry_cycle got=%0d exp=20", n); end
  endtask

  task automatic test_round_robin();
    bit exp_wr;
    wr_req = 1; rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2 == 0);
      tick();
      total++; if (wr_ack_a !== exp_wr || rd_ack_a !== !exp_wr || wr_start_a !== exp_wr || rd_start_a !== !exp_wr)
        begin bad++; $display("FAIL rr_grant%0d got=wa%b ra%b ws%b rs%b exp_wr=%b", i, wr_ack_a, rd_ack_a, wr_start_a, rd_start_a, exp_wr); end
      total++; if (sel_a !== (exp_wr ? 4'b0010 : 4'b1000) || busy_a !== 1'b1)
        begin bad++; $display("FAIL rr_sel%0d got=%b/%b exp_wr=%b", i, sel_a, busy_a, exp_wr); end
      tick(); tick();
      if (exp_wr) wr_done = 1; else rd_done = 1;
      tick(); wr_done = 0; rd_done = 0;
      total++; if (busy_a !== 1'b0 || sel_a !== 4'b1000 || wr_ack_a !== 1'b0 || rd_ack_a !== 1'b0)
        begin bad++; $display("FAIL rr_idle%0d got=%b/%b/%b%b exp=0/1000/00", i, busy_a, sel_a, wr_ack_a, rd_ack_a); end
    end
    wr_req = 0; rd_req = 0;
  endtask

  task automatic test_single_write();
    wr_req = 1; tick();
    total++; if (wr_start_a !== 1'b1 || wr_ack_a !== 1'b1 || sel_a !== 4'b0010)
      begin bad++; $display("FAIL wr_grant got=%b%b/%b exp=11/0010", wr_start_a, wr_ack_a, sel_a); end
    wr_req = 0; tick();
    total++; if (wr_start_a !== 1'b0 || wr_ack_a !== 1'b0) begin bad++; $display("FAIL wr_pulse got=%b%b exp=00", wr_start_a, wr_ack_a); end
    rd_done = 1; tick(); rd_done = 0;
    total++; if (sel_a !== 4'b0010 || busy_a !== 1'b1) begin bad++; $display("FAIL stray_done got=%b/%b exp=0010/1", sel_a, busy_a); end
    tick(); tick();
    wr_done = 1; tick(); wr_done = 0;
    total++; if (sel_a !== 4'b1000 || busy_a !== 1'b0) begin bad++; $display("FAIL wr_done got=%b/%b exp=1000/0", sel_a, busy_a); end
  endtask

  task automatic test_refresh_priority();
    test_power_up();
    repeat (44) tick();
    wr_req = 1; tick();
    total++; if (wr_ack_a !== 1'b1) begin bad++; $display("FAIL refp_wr1 got=%b exp=1", wr_ack_a); end
    repeat (5) tick();
    wr_done = 1; tick(); wr_done = 0;
    total++; if (busy_a !== 1'b0 || wr_ack_a !== 1'b0) begin bad++; $display("FAIL refp_idle got=%b/%b exp=0/0", busy_a, wr_ack_a); end
    tick();
    total++; if (ref_start_a !== 1'b1 || sel_a !== 4'b0100 || wr_ack_a !== 1'b0)
      begin bad++; $display("FAIL refp_ref got=%b/%b/%b exp=1/0100/0", ref_start_a, sel_a, wr_ack_a); end
    total++; if (ref_overrun_a !== 1'b0) begin bad++; $display("FAIL refp_overrun got=%b exp=0", ref_overrun_a); end
    ref_done = 1; tick(); ref_done = 0;
    tick();
    total++; if (wr_ack_a !== 1'b1 || sel_a !== 4'b0010) begin bad++; $display("FAIL refp_wr2 got=%b/%b exp=1/0010", wr_ack_a, sel_a); end
    wr_req = 0; wr_done = 1; tick(); wr_done = 0;
  endtask

  task automatic test_timeout();
    test_power_up();
    repeat (5) tick();
    total++; if (ref_start_b !== 1'b0) begin bad++; $display("FAIL to_early_ref got=%b exp=0", ref_start_b); end
    tick();
    total++; if (ref_start_b !== 1'b1 || sel_b !== 4'b0100) begin bad++; $display("FAIL to_ref_start got=%b/%b exp=1/0100", ref_start_b, sel_b); end
    repeat (9) tick();
    total++; if (timeout_err_b !== 1'b0 || busy_b !== 1'b1) begin bad++; $display("FAIL to_before got=%b/%b exp=0/1", timeout_err_b, busy_b); end
    total++; if (ref_overrun_b !== 1'b1) begin bad++; $display("FAIL to_overrun got=%b exp=1", ref_overrun_b); end
    tick();
    total++; if (timeout_err_b !== 1'b1 || busy_b !== 1'b0 || sel_b !== 4'b1000)
      begin bad++; $display("FAIL to_abort got=%b/%b/%b exp=1/0/1000", timeout_err_b, busy_b, sel_b); end
    tick();
    total++; if (ref_start_b !== 1'b1) begin bad++; $display("FAIL to_reref got=%b exp=1", ref_start_b); end
  endtask

  task automatic test_reset_mid_rd();
    int n = 1;
    bit seen = 0;
    rd_req = 1; tick();
    total++; if (rd_ack_a !== 1'b1 || rd_start_a !== 1'b1 || busy_a !== 1'b1)
      begin bad++; $display("FAIL rdr_grant got=%b%b%b exp=111", rd_ack_a, rd_start_a, busy_a); end
    rd_req = 0; tick();
    rst = 1; tick();
    total++; if (sel_a !== 4'b0001 || ready_a !== 1'b0 || busy_a !== 1'b1 || rd_ack_a !== 1'b0)
      begin bad++; $display("FAIL rdr_rst got=%b/%b/%b/%b exp=0001/0/1/0", sel_a, ready_a, busy_a, rd_ack_a); end
    total++; if (timeout_err_b !== 1'b0 || ref_overrun_b !== 1'b0 || ready_b !== 1'b0 || sel_b !== 4'b0001)
      begin bad++; $display("FAIL rdr_flags got=%b/%b/%b/%b exp=0/0/0/0001", timeout_err_b, ref_overrun_b, ready_b, sel_b); end
    rst = 0; rd_done = 1; tick(); rd_done = 0;
    total++; if (sel_a !== 4'b0001 || busy_a !== 1'b1 || ready_a !== 1'b0)
      begin bad++; $display("FAIL rdr_ignore got=%b/%b/%b exp=0001/1/0", sel_a, busy_a, ready_a); end
    while (!seen && n < 40) begin tick(); n++; if (init_start_a === 1'b1) seen = 1; end
    total++; if (!seen || n != 20) begin bad++; $display("FAIL rdr_reinit got=%0d exp=20", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_power_up();
    test_round_robin();
    test_single_write();
    test_refresh_priority();
    test_timeout();
    test_reset_mid_rd();
    test_init_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
